// File: rtl/relin_key_scheduler.sv
// Round-robin arbiter and tile address sequencer for the shared relinearisation key loader.
// Grant is one cycle after request, and the owner keeps the loader until its whole key has streamed out.
module relin_key_scheduler #(
  parameter int RELIN_KEY_TILE_WIDTH = 8,
  parameter int RELIN_KEY_LENGTH     = 512,
  parameter int NUM_REQ              = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ-1:0]                req_c_sel,
  input  logic                              tile_ready,
  input  logic                              flush,
  output logic [NUM_REQ-1:0]                grant,
  output logic                              c1_or_c0,
  output logic                              valid_address,
  output logic [$clog2(RELIN_KEY_LENGTH):0] address,
  output logic                              last_tile,
  output logic [NUM_REQ-1:0]                burst_done,
  output logic                              busy
);

  localparam int AW = $clog2(RELIN_KEY_LENGTH) + 1;
  localparam int PW = $clog2(NUM_REQ);
  localparam logic [AW-1:0] LAST = AW'(RELIN_KEY_LENGTH - RELIN_KEY_TILE_WIDTH);
  localparam logic [AW-1:0] STEP = AW'(RELIN_KEY_TILE_WIDTH);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic [PW-1:0]        rr_q, rr_d;
  logic                 c1_q, c1_d;
  logic                 vld_q, vld_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [PW-1:0]        cand;
  logic [PW-1:0]        win;
  logic                 found;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      owner_q <= '0;
      rr_q    <= '0;
      c1_q    <= 1'b0;
      vld_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      c1_q    <= c1_d;
      vld_q   <= vld_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    owner_d = owner_q;
    rr_d    = rr_q;
    c1_d    = c1_q;
    vld_d   = vld_q;
    addr_d  = addr_q;
    cand    = '0;
    win     = rr_q;
    found   = 1'b0;

    // Search starts at the round-robin pointer so the previous owner ends up last.
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PW'((int'(rr_q) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end

    if (flush) begin
      state_d = IDLE;
      grant_d = '0;
      c1_d    = 1'b0;
      vld_d   = 1'b0;
      addr_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            state_d = BURST;
            grant_d = NUM_REQ'(1) << win;
            owner_d = win;
            c1_d    = req_c_sel[win];
            vld_d   = 1'b1;
            addr_d  = '0;
          end
        end
        BURST: begin
          if (tile_ready) begin
            if (addr_q == LAST) begin
              state_d = DONE;
              vld_d   = 1'b0;
              addr_d  = '0;
            end else begin
              addr_d = addr_q + STEP;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          done_d  = grant_q;
          grant_d = '0;
          c1_d    = 1'b0;
          rr_d    = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + PW'(1);
        end
        default: begin
          state_d = IDLE;
          grant_d = '0;
          vld_d   = 1'b0;
          addr_d  = '0;
        end
      endcase
    end
  end

  assign grant         = grant_q;
  assign c1_or_c0      = c1_q;
  assign valid_address = vld_q;
  assign address       = addr_q;
  assign burst_done    = done_q;
  assign last_tile     = vld_q && (addr_q == LAST);
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_relin_key_scheduler.sv
// Directed bench for relin_key_scheduler at default parameters (8-word tiles, 512-word key, 2 lanes).
module tb_relin_key_scheduler;

  logic       clk;
  logic       reset;
  logic [1:0] req;
  logic [1:0] req_c_sel;
  logic       tile_ready;
  logic       flush;
  logic [1:0] grant;
  logic       c1_or_c0;
  logic       valid_address;
  logic [9:0] address;
  logic       last_tile;
  logic [1:0] burst_done;
  logic       busy;

  int checks;
  int failures;

  relin_key_scheduler #(
    .RELIN_KEY_TILE_WIDTH(8),
    .RELIN_KEY_LENGTH(512),
    .NUM_REQ(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .req_c_sel(req_c_sel),
    .tile_ready(tile_ready),
    .flush(flush),
    .grant(grant),
    .c1_or_c0(c1_or_c0),
    .valid_address(valid_address),
    .address(address),
    .last_tile(last_tile),
    .burst_done(burst_done),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b0; req = 2'b00; req_c_sel = 2'b00; tile_ready = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 2'b00; req_c_sel = 2'b00; tile_ready = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b exp=00", grant); end
    checks++; if (valid_address !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_address); end
    checks++; if (address !== 10'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", address); end
    checks++; if (burst_done !== 2'b00) begin failures++; $display("FAIL reset_done got=%b exp=00", burst_done); end
    checks++; if ({busy, last_tile, c1_or_c0} !== 3'b000) begin failures++; $display("FAIL reset_misc got=%b exp=000", {busy, last_tile, c1_or_c0}); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_noreq_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single();
    req = 2'b01; req_c_sel = 2'b01; tile_ready = 1'b1;
    @(negedge clk);
    checks++; if (grant !== 2'b01) begin failures++; $display("FAIL single_grant got=%b exp=01", grant); end
    checks++; if (c1_or_c0 !== 1'b1) begin failures++; $display("FAIL single_c1 got=%b exp=1", c1_or_c0); end
    checks++; if (valid_address !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", valid_address); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
    req = 2'b00;
    for (int t = 0; t < 64; t++) begin
      checks++; if (address !== 10'(t * 8)) begin failures++; $display("FAIL single_addr t=%0d got=%0d exp=%0d", t, address, t * 8); end
      checks++; if (last_tile !== (t == 63)) begin failures++; $display("FAIL single_last t=%0d got=%b exp=%b", t, last_tile, (t == 63)); end
      @(negedge clk);
    end
    checks++; if ({busy, valid_address, burst_done} !== 4'b1000) begin failures++; $display("FAIL single_done_state got=%b exp=1000", {busy, valid_address, burst_done}); end
    checks++; if (address !== 10'd0) begin failures++; $display("FAIL single_done_addr got=%0d exp=0", address); end
    @(negedge clk);
    checks++; if (burst_done !== 2'b01) begin failures++; $display("FAIL single_burst_done got=%b exp=01", burst_done); end
    checks++; if ({grant, busy, c1_or_c0} !== 4'b0000) begin failures++; $display("FAIL single_release got=%b exp=0000", {grant, busy, c1_or_c0}); end
    @(negedge clk);
    checks++; if (burst_done !== 2'b00) begin failures++; $display("FAIL single_done_pulse_width got=%b exp=00", burst_done); end
  endtask

  task automatic test_contention();
    logic [1:0] g [3];
    logic       c [3];
    int         at [3];
    int         n;
    logic [1:0] prev;
    logic [1:0] first_done;
    do_reset();
    req = 2'b11; req_c_sel = 2'b10; tile_ready = 1'b1;
    n = 0; prev = 2'b00; first_done = 2'b00;
    for (int cyc = 0; cyc < 260 && n < 3; cyc++) begin
      @(negedge clk);
      if (grant != 2'b00 && prev == 2'b00) begin
        g[n] = grant; c[n] = c1_or_c0; at[n] = cyc; n++;
      end
      if (burst_done != 2'b00 && first_done == 2'b00) first_done = burst_done;
      prev = grant;
    end
    checks++;
    if (n != 3) begin
      failures++; $display("FAIL contention_timeout grants=%0d exp=3", n);
    end else begin
      checks++; if (g[0] !== 2'b01) begin failures++; $display("FAIL contention_g0 got=%b exp=01", g[0]); end
      checks++; if (g[1] !== 2'b10) begin failures++; $display("FAIL contention_g1 got=%b exp=10", g[1]); end
      checks++; if (g[2] !== 2'b01) begin failures++; $display("FAIL contention_g2 got=%b exp=01", g[2]); end
      checks++; if ({c[0], c[1], c[2]} !== 3'b010) begin failures++; $display("FAIL contention_c1 got=%b exp=010", {c[0], c[1], c[2]}); end
      checks++; if (at[1] - at[0] != 66) begin failures++; $display("FAIL contention_period01 got=%0d exp=66", at[1] - at[0]); end
      checks++; if (at[2] - at[1] != 66) begin failures++; $display("FAIL contention_period12 got=%0d exp=66", at[2] - at[1]); end
      checks++; if (first_done !== 2'b01) begin failures++; $display("FAIL contention_done_lane got=%b exp=01", first_done); end
    end
    req = 2'b00;
  endtask

  task automatic test_backpressure();
    int   exp_addr;
    int   bc;
    logic ph;
    logic [1:0] done_seen;
    do_reset();
    req = 2'b01; req_c_sel = 2'b00; tile_ready = 1'b0;
    @(negedge clk);
    req = 2'b00;
    checks++; if (c1_or_c0 !== 1'b0) begin failures++; $display("FAIL bp_c0 got=%b exp=0", c1_or_c0); end
    exp_addr = 0; bc = 0; ph = 1'b1;
    while (valid_address === 1'b1 && bc < 300) begin
      checks++; if (address !== 10'(exp_addr)) begin failures++; $display("FAIL bp_addr cyc=%0d got=%0d exp=%0d", bc, address, exp_addr); end
      tile_ready = ph;
      if (ph) exp_addr += 8;
      ph = ~ph;
      bc++;
      @(negedge clk);
    end
    checks++; if (bc != 127) begin failures++; $display("FAIL bp_burst_cycles got=%0d exp=127", bc); end
    done_seen = 2'b00;
    for (int i = 0; i < 4; i++) begin
      if (burst_done != 2'b00) done_seen = burst_done;
      @(negedge clk);
    end
    checks++; if (done_seen !== 2'b01) begin failures++; $display("FAIL bp_done got=%b exp=01", done_seen); end
  endtask

  task automatic test_req_drop();
    int tiles;
    do_reset();
    req = 2'b10; req_c_sel = 2'b10; tile_ready = 1'b1;
    @(negedge clk);
    checks++; if (grant !== 2'b10) begin failures++; $display("FAIL drop_grant got=%b exp=10", grant); end
    checks++; if (c1_or_c0 !== 1'b1) begin failures++; $display("FAIL drop_c1 got=%b exp=1", c1_or_c0); end
    req = 2'b00; req_c_sel = 2'b00;
    tiles = 0;
    while (valid_address === 1'b1 && tiles < 100) begin
      tiles++;
      if (tiles == 32) begin
        checks++; if ({grant, c1_or_c0} !== 3'b101) begin failures++; $display("FAIL drop_hold got=%b exp=101", {grant, c1_or_c0}); end
      end
      @(negedge clk);
    end
    checks++; if (tiles != 64) begin failures++; $display("FAIL drop_tiles got=%0d exp=64", tiles); end
    @(negedge clk);
    checks++; if (burst_done !== 2'b10) begin failures++; $display("FAIL drop_done got=%b exp=10", burst_done); end
  endtask

  task automatic test_flush();
    int   w;
    logic any_done;
    do_reset();
    req = 2'b01; req_c_sel = 2'b00; tile_ready = 1'b1;
    w = 0;
    while (!(valid_address === 1'b1 && address === 10'd256) && w < 100) begin
      @(negedge clk); w++;
    end
    checks++;
    if (w >= 100) begin
      failures++; $display("FAIL flush_reach_256 got=%0d exp=256", address);
    end else begin
      flush = 1'b1; req = 2'b00;
      @(negedge clk);
      flush = 1'b0;
      checks++; if ({busy, valid_address, grant} !== 4'b0000) begin failures++; $display("FAIL flush_state got=%b exp=0000", {busy, valid_address, grant}); end
      checks++; if (address !== 10'd0) begin failures++; $display("FAIL flush_addr got=%0d exp=0", address); end
      any_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (burst_done != 2'b00) any_done = 1'b1;
        @(negedge clk);
      end
      checks++; if (any_done !== 1'b0) begin failures++; $display("FAIL flush_no_done got=%b exp=0", any_done); end
      req = 2'b11;
      @(negedge clk);
      checks++; if (grant !== 2'b01) begin failures++; $display("FAIL flush_rr_kept got=%b exp=01", grant); end
      req = 2'b00;
    end
  endtask

  task automatic test_reset_mid();
    int   w;
    logic any_done;
    do_reset();
    req = 2'b01; req_c_sel = 2'b01; tile_ready = 1'b1;
    w = 0;
    while (!(valid_address === 1'b1 && address === 10'd128) && w < 100) begin
      @(negedge clk); w++;
    end
    checks++;
    if (w >= 100) begin
      failures++; $display("FAIL rstmid_reach_128 got=%0d exp=128", address);
    end else begin
      #2;
      reset = 1'b0;
      #1;
      checks++; if ({grant, valid_address, c1_or_c0, busy, last_tile} !== 6'b000000) begin failures++; $display("FAIL rstmid_async got=%b exp=000000", {grant, valid_address, c1_or_c0, busy, last_tile}); end
      checks++; if ({address, burst_done} !== 12'd0) begin failures++; $display("FAIL rstmid_addr_done got=%0d/%b exp=0/00", address, burst_done); end
      req = 2'b10;
      @(negedge clk);
      reset = 1'b1;
      any_done = 1'b0;
      @(negedge clk);
      if (burst_done != 2'b00) any_done = 1'b1;
      checks++; if (grant !== 2'b10) begin failures++; $display("FAIL rstmid_regrant got=%b exp=10", grant); end
      checks++; if (any_done !== 1'b0) begin failures++; $display("FAIL rstmid_no_done got=%b exp=0", any_done); end
      req = 2'b00;
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0; req = 2'b00; req_c_sel = 2'b00; tile_ready = 1'b0; flush = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_req_drop();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/relin_key_scheduler.md
RELIN_KEY_SCHEDULER -- requirements
Module: relin_key_scheduler

Interface
REQ-001 SHALL have parameter RELIN_KEY_TILE_WIDTH, default 8: key words delivered per tile.
REQ-002 SHALL have parameter RELIN_KEY_LENGTH, default 512: key words per key; SHALL be an integer multiple of RELIN_KEY_TILE_WIDTH.
REQ-003 SHALL have parameter NUM_REQ, default 2: number of multiplier lanes sharing the key loader; SHALL be at least 2.
REQ-004 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port req, input, NUM_REQ bits: per-lane burst request, level-sensitive.
REQ-007 SHALL have port req_c_sel, input, NUM_REQ bits: per-lane key half select (1 = c1, 0 = c0), sampled at grant.
REQ-008 SHALL have port tile_ready, input, 1 bit: the granted lane accepts the current tile.
REQ-009 SHALL have port flush, input, 1 bit: synchronous abort.
REQ-010 SHALL have port grant, output, NUM_REQ bits: one-hot owner of the key loader; all zero when no lane owns it.
REQ-011 SHALL have port c1_or_c0, output, 1 bit: key half select driven to the key register file mux.
REQ-012 SHALL have port valid_address, output, 1 bit: the current address/tile is valid.
REQ-013 SHALL have port address, output, $clog2(RELIN_KEY_LENGTH)+1 bits: base word index of the current tile.
REQ-014 SHALL have port last_tile, output, 1 bit: valid_address is 1 and address equals LAST = RELIN_KEY_LENGTH-RELIN_KEY_TILE_WIDTH.
REQ-015 SHALL have port burst_done, output, NUM_REQ bits: one-cycle completion pulse to the owning lane.
REQ-016 SHALL have port busy, output, 1 bit: state is not IDLE.

Function
REQ-017 SHALL implement the states IDLE, BURST and DONE; grant, c1_or_c0, valid_address, address and burst_done SHALL be registered.
REQ-018 IDLE with any req bit set SHALL select a winner by round-robin, starting the search at rr_ptr and wrapping modulo NUM_REQ.
REQ-019 On that selection edge, the block SHALL set grant to the winner's one-hot value, latch c1_or_c0 from req_c_sel[winner], set address to 0, set valid_address to 1 and enter BURST, giving 1 cycle of latency from req to valid_address.
REQ-020 IDLE with req all zero SHALL hold all outputs at their reset values.
REQ-021 BURST with tile_ready=0 SHALL hold address, grant and c1_or_c0 (stall).
REQ-022 BURST with tile_ready=1 and address below LAST SHALL advance address by RELIN_KEY_TILE_WIDTH.
REQ-023 BURST with tile_ready=1 and address equal to LAST SHALL clear valid_address, set address to 0 and enter DONE.
REQ-024 A full burst SHALL be RELIN_KEY_LENGTH/RELIN_KEY_TILE_WIDTH accepted tiles (64 at defaults) and SHALL take 64 cycles when tile_ready is held at 1.
REQ-025 DONE SHALL pulse burst_done[owner] for exactly one cycle, clear grant, set rr_ptr to (owner+1) mod NUM_REQ and return to IDLE.
REQ-026 Back-to-back bursts SHALL repeat every 66 cycles at defaults: 1 IDLE cycle, 64 BURST cycles and 1 DONE cycle.
REQ-027 Arbitration SHALL be non-preemptive: deassertion or change of req, or a change of req_c_sel, during BURST or DONE SHALL be ignored until the next IDLE.
REQ-028 A lane still holding req after its burst_done SHALL be treated as a new request and SHALL receive the lowest round-robin priority.
REQ-029 flush=1 in any state SHALL force IDLE, clear grant, valid_address and address, produce no burst_done pulse and leave rr_ptr unchanged.
REQ-030 When flush and tile_ready are both 1 in the same cycle, flush SHALL win.
REQ-031 grant SHALL never have more than one bit set.
REQ-032 address SHALL never exceed LAST and SHALL be a multiple of RELIN_KEY_TILE_WIDTH.

Reset
REQ-033 reset=0 SHALL immediately force IDLE, set grant, address, valid_address, burst_done, c1_or_c0 and rr_ptr to 0, and make busy and last_tile read 0.
REQ-034 Reset asserted mid-burst SHALL abandon the burst with no burst_done pulse.
REQ-035 After reset release, the first arbitration SHALL favour lane 0.

Verification
REQ-036 Single request, req=01, req_c_sel=01, tile_ready=1 -> grant=01 and c1_or_c0=1 one cycle later; address steps 0, 8, ... 504; last_tile=1 at address 504; burst_done=01 two cycles after the last accepted tile.
REQ-037 Contention, req=11 held, tile_ready=1 -> grants alternate 01, 10, 01, with a grant edge every 66 cycles.
REQ-038 Backpressure, tile_ready toggling 1,0 -> address advances only on ready cycles; the burst completes in 127 cycles.
REQ-039 flush asserted at address 256, together with tile_ready=1 -> next cycle is IDLE with address=0 and grant=00; no burst_done; rr_ptr unchanged.
REQ-040 reset pulsed low at address 128 -> all outputs 0 asynchronously; after release with req=10, grant=10.
REQ-041 req dropped to 00 mid-burst -> the burst still completes 64 tiles and burst_done pulses.
